// File: rtl/intersection_phase_scheduler.sv
// Four-approach round-robin intersection phase scheduler: green -> yellow -> all-red per grant.
// Define EMERGENCY_PREEMPT_EN to add emergency preemption inputs emerg_req / emerg_id.
module intersection_phase_scheduler #(
  parameter int unsigned TICK_DIV  = 4,
  parameter int unsigned MIN_GREEN = 5,
  parameter int unsigned MAX_GREEN = 10,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned TW        = 28
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic        emerg_req,
  input  logic [1:0]  emerg_id,
`endif
  output logic [11:0] light,
  output logic        grant_valid,
  output logic [1:0]  grant_id,
  output logic [3:0]  pending,
  output logic        phase_start
);

  localparam logic [2:0] LampR = 3'b100;
  localparam logic [2:0] LampY = 3'b010;
  localparam logic [2:0] LampG = 3'b001;

  typedef enum logic [1:0] {StIdle, StGreen, StYellow, StAllred} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] div_q, div_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    last_q, last_d;
  logic [3:0]    pending_q, pending_d;
  logic          phase_start_q;

  logic          tick;
  logic          min_done, max_done, yellow_done, allred_done;
  logic [1:0]    winner, cand, green_id;
  logic          found, enter_green;
  logic [3:0]    grant_mask, clear_mask, others;
  logic          emerg_on;
  logic [1:0]    emerg_tgt;

`ifdef EMERGENCY_PREEMPT_EN
  assign emerg_on  = emerg_req;
  assign emerg_tgt = emerg_id;
`else
  assign emerg_on  = 1'b0;
  assign emerg_tgt = 2'd0;
`endif

  assign grant_valid = (state_q == StGreen) || (state_q == StYellow);
  assign grant_id    = grant_q;
  assign pending     = pending_q;
  assign phase_start = phase_start_q;

  // A phase of N ticks is complete on the tick where the timer still reads N-1.
  assign tick        = (div_q == TW'(TICK_DIV - 1));
  assign min_done    = tick && (timer_q >= TW'(MIN_GREEN - 1));
  assign max_done    = tick && (timer_q >= TW'(MAX_GREEN - 1));
  assign yellow_done = tick && (timer_q >= TW'(YELLOW_T - 1));
  assign allred_done = tick && (timer_q >= TW'(ALLRED_T - 1));

  assign grant_mask = grant_valid ? (4'b0001 << grant_q) : 4'b0000;
  assign others     = pending_q & ~grant_mask;

  // Round-robin search starting just after the last served approach.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    cand   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && pending_q[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    enter_green = 1'b0;
    green_id    = winner;
    unique case (state_q)
      StIdle: begin
        if (emerg_on) begin
          enter_green = 1'b1;
          green_id    = emerg_tgt;
        end else if (|pending_q) begin
          enter_green = 1'b1;
        end
      end
      StGreen: begin
        if (emerg_on) begin
          // Foreign emergency cuts green short; own emergency holds green indefinitely.
          if ((emerg_tgt != grant_q) && tick) state_d = StYellow;
        end else if (min_done && (|others) && (!req[grant_q] || max_done)) begin
          state_d = StYellow;
        end
      end
      StYellow: begin
        if (yellow_done) state_d = StAllred;
      end
      StAllred: begin
        if (allred_done) begin
          if (emerg_on) begin
            enter_green = 1'b1;
            green_id    = emerg_tgt;
          end else if (|pending_q) begin
            enter_green = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (enter_green) begin
      state_d = StGreen;
      grant_d = green_id;
      if (!emerg_on) last_d = green_id;
    end
  end

  assign clear_mask = enter_green ? (4'b0001 << green_id) : 4'b0000;
  // Clear on green entry wins over a same-clock set.
  assign pending_d  = (pending_q | (req & ~grant_mask)) & ~clear_mask;

  always_comb begin
    div_d   = div_q;
    timer_d = timer_q;
    if (state_d != state_q) begin
      div_d   = '0;
      timer_d = '0;
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      // Saturate so a long rest in green cannot wrap back below the thresholds.
      if (tick && (timer_q != '1)) timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      div_q         <= '0;
      timer_q       <= '0;
      grant_q       <= 2'd0;
      last_q        <= 2'd3;
      pending_q     <= 4'b0000;
      phase_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      timer_q       <= timer_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      pending_q     <= pending_d;
      phase_start_q <= enter_green;
    end
  end

  always_comb begin
    light = {LampR, LampR, LampR, LampR};
    for (int i = 0; i < 4; i++) begin
      if (grant_valid && (grant_q == 2'(i))) begin
        light[3*i +: 3] = (state_q == StGreen) ? LampG : LampY;
      end
    end
  end

  logic [3:0] red_bits;
  assign red_bits = {light[11], light[8], light[5], light[2]};

  a_one_active: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(~red_bits));
  a_grant_lit:  assert property (@(posedge clk) disable iff (!rst_n) grant_valid == !(&red_bits));

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
- Four-approach intersection phase scheduler. Shares the single "right of way" resource among four approach sensors.
- Latches car requests and grants green to one approach at a time in round-robin order.
- Sequences each grant through green, yellow and all-red clearance using tick-based timers.
- Drives the per-approach lamp codes consumed by the lamp driver layer.

Parameters:
- TICK_DIV, 4: clocks per timing tick (4 for simulation, 50_000_000 for 50 MHz hardware).
- MIN_GREEN, 5: minimum green length, in ticks.
- MAX_GREEN, 10: maximum green length while another approach is waiting, in ticks.
- YELLOW_T, 3: yellow length, in ticks.
- ALLRED_T, 1: all-red clearance length, in ticks.
- TW, 28: width of the tick divider and phase timer.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  level sensor per approach; 1 = car present
- light  output  12  lamp code, 3 bits per approach ([3i+2:3i] = approach i); R=100, Y=010, G=001
- grant_valid  output  1  1 while some approach is green or yellow
- grant_id  output  2  approach currently holding green or yellow
- pending  output  4  latched unserved requests
- phase_start  output  1  one-clock pulse on the clock a GREEN phase begins

Behaviour:
- One clock, clk. Reset is asynchronous and active-low, on rst_n.
- Reset values:
  - state=IDLE, light=12'h924 (all red), grant_valid=0, grant_id=0, pending=0, phase_start=0.
  - Tick divider and phase timer = 0. Round-robin pointer last=3, so approach 0 has first priority.
- Tick generation:
  - Divider counts 0..TICK_DIV-1; tick=1 when divider==TICK_DIV-1.
  - Divider and timer clear on every state transition, so a phase of N ticks lasts exactly N*TICK_DIV clocks.
  - Timer increments on each tick.
- Request latching:
  - pending[i] sets when req[i]=1.
  - pending[i] clears on the clock approach i enters GREEN. Clear wins over a simultaneous set.
  - req[i] of the approach currently green/yellow does not set pending[i].
- Selection: winner = first set pending bit searching last+1, last+2, ... modulo 4. The winner is written to last on entering GREEN.
- States, all registered; outputs decoded from registered state:
  - IDLE:
    - All red, grant_valid=0.
    - If pending!=0, go to GREEN(winner) on the next clock. No all-red needed, since IDLE is already all red.
  - GREEN:
    - Lamp of grant_id is G; all others R. phase_start pulses on entry.
    - Others = pending with the grant_id bit masked.
    - Before timer reaches MIN_GREEN ticks: stay.
    - After MIN_GREEN: if others==0, rest in green indefinitely.
    - Else go to YELLOW when req[grant_id]==0 (gap-out), or when timer reaches MAX_GREEN ticks (max-out), whichever comes first.
    - All transitions occur on a tick boundary.
  - YELLOW: lamp of grant_id is Y; after YELLOW_T ticks go to ALLRED.
  - ALLRED:
    - All red, grant_valid=0, grant_id holds its last value.
    - After ALLRED_T ticks: go to GREEN(winner) if pending!=0, else IDLE.
- Exactly one approach is non-red at any time. Any other lamp combination is illegal and must never appear.
- Reset mid-phase: lamps go to all red immediately (asynchronous), and pending is lost.
- Parameter constraints: MIN_GREEN <= MAX_GREEN; all timing parameters >= 1.

Optional Feature:
- Macro: EMERGENCY_PREEMPT_EN
- Defined: adds inputs emerg_req (1 bit) and emerg_id (2 bits).
  - While emerg_req=1 and grant_id!=emerg_id (or not green): GREEN exits to YELLOW on the next tick, ignoring MIN_GREEN. ALLRED is then followed by GREEN(emerg_id) regardless of round-robin; last is not updated.
  - GREEN(emerg_id) is held while emerg_req=1, ignoring MAX_GREEN.
  - On release, normal rules resume.
  - IDLE with emerg_req=1 goes directly to GREEN(emerg_id).
- Undefined: the ports do not exist and there is no preemption logic.

Test Plan:
- Defaults for all scenarios: TICK_DIV=4, MIN_GREEN=5, MAX_GREEN=10, YELLOW_T=3, ALLRED_T=1.
- Reset: hold rst_n=0 -> light=12'h924, grant_valid=0, pending=0; assert rst_n mid-YELLOW -> light=12'h924 in the same cycle.
- Single request: pulse req[2] for 1 clk from IDLE -> two clocks later grant_id=2, light=12'h864, phase_start=1 for 1 clk; green holds for 200 clocks with no other requests.
- Gap-out: green on 2; set req[0] and drop req[2] -> yellow starts exactly 20 clocks after green entry; yellow 12 clks; all-red 4 clks; then green on 0.
- Max-out plus round-robin: green on 1 with req[1] held high; pending={3,0} -> green on 1 lasts 40 clks, then 3 is served, then 0.
- Simultaneous set/clear: req[3]=1 on the clock 3 enters GREEN -> pending[3]=0 after that edge.
- Preempt (macro defined): emerg_req=1, emerg_id=2 at timer=1 of green on 0 -> yellow on next tick, all-red, then green on 2 held until emerg_req falls.
